// File: rtl/bin_to_bcd_scan_driver_pkg.sv
// Shared constants, FSM encoding and the BCD nibble-correction helper
// used by the binary-to-BCD scan driver.
package bin_to_bcd_scan_driver_pkg;

  localparam int          NUM_DIGITS  = 8;
  localparam int          DIGIT_W     = 4;
  localparam int          BCD_W       = NUM_DIGITS * DIGIT_W;
  localparam int unsigned MAX_DISPLAY = 32'd99_999_999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Double-dabble correction: every nibble >= 5 gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        res[i*DIGIT_W +: DIGIT_W] = acc[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end else begin
        res[i*DIGIT_W +: DIGIT_W] = acc[i*DIGIT_W +: DIGIT_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin_to_bcd_scan_driver_digit_scan_ctr.sv
// Refresh prescaler and digit index counter. The index advances by one
// (mod 8) on the cycle the prescaler wraps; wrap is exposed so the parent
// can look ahead to the next index in the same cycle.
module digit_scan_ctr
  import bin_to_bcd_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] anum,
  output logic       wrap
);

  localparam int            PW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;

  assign wrap = (presc == LAST);

  // Prescaler counts 0..REFRESH_DIV-1; digit index steps on the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      anum  <= 3'd0;
    end else if (wrap) begin
      presc <= '0;
      anum  <= anum + 3'd1;
    end else begin
      presc <= presc + PW'(1);
      anum  <= anum;
    end
  end

endmodule

// File: rtl/bin_to_bcd_scan_driver.sv
// Binary stopwatch count -> packed BCD (sequential double-dabble), then
// time-multiplexed onto a single BCD digit bus plus digit index.
module bin_to_bcd_scan_driver
  import bin_to_bcd_scan_driver_pkg::*;
#(
  parameter int NUM_BITS    = 27,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] bin_in,
  input  logic                bin_valid,
  output logic                bin_ready,
  output logic                conv_done,
  output logic [3:0]          v,
  output logic [2:0]          anum
);

  localparam int                  CW      = $clog2(NUM_BITS + 1);
  localparam int                  ADJ_W   = BCD_W - 1;
  localparam logic [NUM_BITS-1:0] MAX_BIN = NUM_BITS'(MAX_DISPLAY);

  conv_state_t         state;
  logic [NUM_BITS-1:0] shreg;
  logic [BCD_W-1:0]    acc;
  logic [CW-1:0]       iter;
  logic [BCD_W-1:0]    display;

  logic [NUM_BITS-1:0] bin_clamped;
  logic [ADJ_W-1:0]    acc_adj;
  logic                wrap;
  logic [2:0]          anum_next;

  // Clamping keeps the top digit <= 9, so the corrected accumulator's MSB
  // is never set when it is shifted out; only the low bits are kept.
  assign bin_clamped = (bin_in > MAX_BIN) ? MAX_BIN : bin_in;
  assign acc_adj     = ADJ_W'(add3_nibbles(acc));

  // Conversion FSM: accept, shift NUM_BITS times, commit to display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      iter      <= '0;
      display   <= '0;
      bin_ready <= 1'b1;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bin_valid && bin_ready) begin
            shreg     <= bin_clamped;
            acc       <= '0;
            iter      <= CW'(NUM_BITS);
            bin_ready <= 1'b0;
            state     <= SHIFT;
          end else begin
            bin_ready <= 1'b1;
          end
        end
        SHIFT: begin
          acc   <= {acc_adj, shreg[NUM_BITS-1]};
          shreg <= {shreg[NUM_BITS-2:0], 1'b0};
          iter  <= iter - CW'(1);
          if (iter == CW'(1)) begin
            state <= COMMIT;
          end else begin
            state <= SHIFT;
          end
        end
        COMMIT: begin
          display   <= acc;
          conv_done <= 1'b1;
          bin_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bin_ready <= 1'b1;
        end
      endcase
    end
  end

  digit_scan_ctr #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk (clk),
    .rst (rst),
    .anum(anum),
    .wrap(wrap)
  );

  assign anum_next = wrap ? (anum + 3'd1) : anum;

  // Digit bus follows the index it will carry after this edge, refreshed
  // every cycle so a new commit shows up without waiting for a slot change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 4'd0;
    end else begin
      v <= display[{anum_next, 2'b00} +: DIGIT_W];
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_scan_driver.sv
// Self-checking bench for bin_to_bcd_scan_driver (REFRESH_DIV = 4).
module tb_bin_to_bcd_scan_driver;

  localparam int NB  = 27;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] bin_in;
  logic          bin_valid;
  logic          bin_ready;
  logic          conv_done;
  logic [3:0]    v;
  logic [2:0]    anum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bin_to_bcd_scan_driver #(
    .NUM_BITS   (NB),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .conv_done(conv_done),
    .v        (v),
    .anum     (anum)
  );

  typedef struct {
    logic [NB-1:0] val;
    logic [31:0]   bcd;
    string         name;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Decimal digits of the clamped value, computed arithmetically.
  function automatic logic [31:0] ref_bcd(input longint unsigned x);
    logic [31:0]     r;
    longint unsigned p;
    if (x > 64'd99999999) x = 64'd99999999;
    r = 32'd0;
    p = 64'd1;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'((x / p) % 64'd10);
      p = p * 64'd10;
    end
    return r;
  endfunction

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (conv_done !== 1'b1 && lat < lat0 + 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Sample one full scan period and rebuild the displayed value.
  task automatic scan_check(input logic [31:0] expv, input string name);
    logic [31:0] got;
    logic [7:0]  seen;
    got  = 32'd0;
    seen = 8'd0;
    for (int k = 0; k < 8 * DIV; k++) begin
      got[anum*4 +: 4] = v;
      seen[anum]       = 1'b1;
      @(negedge clk);
    end
    chk({name, "_scan"}, got, expv);
    chk({name, "_all_slots"}, {24'd0, seen}, 32'hFF);
  endtask

  task automatic convert(input logic [NB-1:0] val, input logic [31:0] expv, input string name);
    int lat;
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, bin_ready}, 32'd1);
    bin_in    = val;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    chk({name, "_busy"}, {31'd0, bin_ready}, 32'd0);
    wait_done(0, lat);
    chk({name, "_latency"}, lat, 32'd28);
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'd0, conv_done}, 32'd0);
    chk({name, "_commit_v"}, {28'd0, v}, {28'd0, expv[anum*4 +: 4]});
    scan_check(expv, name);
  endtask

  initial begin
    int          lat;
    logic [NB-1:0] x;
    logic [31:0] e42;

    vecs[0] = '{val: 27'd0,         bcd: 32'h00000000, name: "zero"};
    vecs[1] = '{val: 27'd99999999,  bcd: 32'h99999999, name: "max"};
    vecs[2] = '{val: 27'd134217727, bcd: 32'h99999999, name: "clamp"};
    vecs[3] = '{val: 27'd42,        bcd: 32'h00000042, name: "small"};
    vecs[4] = '{val: 27'd12345678,  bcd: 32'h12345678, name: "digits"};

    rst       = 1'b1;
    bin_valid = 1'b0;
    bin_in    = '0;
    repeat (2) @(negedge clk);
    chk("rst_v",     {28'd0, v},         32'd0);
    chk("rst_anum",  {29'd0, anum},      32'd0);
    chk("rst_ready", {31'd0, bin_ready}, 32'd1);
    chk("rst_done",  {31'd0, conv_done}, 32'd0);
    rst = 1'b0;

    // Index steps every DIV cycles after release and wraps 7 -> 0.
    for (int k = 1; k <= 9 * DIV; k++) begin
      @(negedge clk);
      chk("anum_step", {29'd0, anum}, (k / DIV) % 8);
    end

    for (int i = 0; i < 5; i++) begin
      convert(vecs[i].val, vecs[i].bcd, vecs[i].name);
    end

    // New display must reach v the cycle after commit (every digit differs).
    convert(27'd1234, 32'h00001234, "slot_commit");

    // Back-to-back: 7 offered during the 42 conversion is ignored, then accepted.
    e42 = 32'h00000042;
    @(negedge clk);
    bin_in    = 27'd42;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_in = 27'd7;
    chk("b2b_busy", {31'd0, bin_ready}, 32'd0);
    wait_done(0, lat);
    chk("b2b_first_latency", lat, 32'd28);
    @(negedge clk);
    chk("b2b_first_v", {28'd0, v}, {28'd0, e42[anum*4 +: 4]});
    chk("b2b_second_accept", {31'd0, bin_ready}, 32'd0);
    bin_valid = 1'b0;
    wait_done(29, lat);
    chk("b2b_second_latency", lat, 32'd57);
    @(negedge clk);
    scan_check(32'h00000007, "b2b_second");

    for (int i = 0; i < 8; i++) begin
      x = NB'($urandom_range(0, 134217727));
      convert(x, ref_bcd(x), "rand");
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    bin_in    = 27'd55555555;
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_v",     {28'd0, v},         32'd0);
    chk("async_rst_anum",  {29'd0, anum},      32'd0);
    chk("async_rst_ready", {31'd0, bin_ready}, 32'd1);
    chk("async_rst_done",  {31'd0, conv_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_done(0, lat);
    chk("midrst_no_done", {31'd0, conv_done}, 32'd0);
    chk("midrst_ready",   {31'd0, bin_ready}, 32'd1);
    scan_check(32'h00000000, "midrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_scan_driver.md
Name: bin_to_bcd_scan_driver

Overview:
Drives the v/anum inputs of the seven-segment BCD decoder. Accepts a binary stopwatch count (up to 8 decimal digits) over a valid/ready handshake and converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine. Time-multiplexes the 8 digits onto the single BCD digit bus and 3-bit anode index at a fixed refresh rate. Sits between the stopwatch/Ethernet master controller and the BCD decoder.

Parameters:
NUM_BITS, 27, binary input width; 2^27 covers 99,999,999.
REFRESH_DIV, 100000, clk cycles each digit is held on v/anum (>=2).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
bin_in  input  NUM_BITS  binary value to display
bin_valid  input  1  bin_in valid; accepted when bin_valid & bin_ready
bin_ready  output  1  high only in IDLE
conv_done  output  1  one-cycle pulse when new digits are committed to display
v  output  4  BCD digit currently scanned, 0..9
anum  output  3  index of digit on v; 0 = least significant

Behaviour:
- Reset, asynchronous and active-high, forces:
  - bin_ready=1, conv_done=0, v=0, anum=0.
  - Display digit register all 0; prescaler 0; FSM IDLE.
  - Clears any in-progress conversion; display shows 00000000.
- Conversion FSM:
  - IDLE: bin_ready=1. On bin_valid: latch min(bin_in, 99_999_999) into the shift register, clear the 32-bit BCD accumulator, load the iteration counter with NUM_BITS, go to SHIFT. bin_ready is 0 from the next cycle.
  - SHIFT: each cycle, add 3 to every accumulator nibble >=5, then shift {acc, bin} left by 1 and decrement the counter. After NUM_BITS cycles, go to COMMIT.
  - COMMIT: copy the accumulator to the display register atomically, pulse conv_done=1 for one cycle, return to IDLE.
  - Latency: handshake at cycle 0; conv_done and the display update at cycle NUM_BITS+1 (28 by default). Next accept is possible at cycle NUM_BITS+2.
- bin_valid while bin_ready=0 is ignored. No queuing; the upstream block holds or drops the value.
- Every accumulator nibble stays 0..9 by construction. The clamp guarantees no digit-7 overflow.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle, anum increments modulo 8 (7 -> 0).
  - v and anum are registered. v <= display[anum_next] in the same edge that anum changes, and also on every edge, so the display is always coherent.
  - A display commit is reflected on v one cycle after COMMIT, without waiting for the next digit slot.
- The scan runs continuously and is independent of the FSM. Conversion never stalls or glitches anum.
- Reset mid-conversion: the partial result is discarded and the display clears to 0.

Decomposition:
- Shared package holds:
  - NUM_DIGITS=8.
  - MAX_DISPLAY=99_999_999.
  - Digit width 4.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- One sub-module, digit_scan_ctr: prescaler plus anum counter with REFRESH_DIV parameter. Outputs anum and a wrap strobe.
- The add-3/shift datapath stays inline in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> immediate v=0, anum=0, bin_ready=1, conv_done=0; after release with REFRESH_DIV=4, anum steps 0,1,..,7,0 every 4 cycles.
- Load bin_in=12345678 -> conv_done at cycle 28; scanning anum=0..7 then yields v=8,7,6,5,4,3,2,1.
- Boundary values:
  - bin_in=0 -> all digits 0.
  - bin_in=99999999 -> all 9.
  - bin_in=134217727 -> clamped to all 9.
- Back-to-back: accept 42; assert bin_valid=1 with bin_in=7 during SHIFT -> ignored, display shows ...00000042. Then 7 is accepted at cycle 29 if still valid, and conv_done fires at cycle 57.
- Reset mid-conversion: accept 55555555, assert rst at cycle 10 -> no conv_done, display reads all 0, bin_ready=1 after release.
- Commit during a digit slot: REFRESH_DIV=64, anum held at 3, commit 00001234 -> v changes to 1 the cycle after conv_done, with anum unchanged.
